tensor_rd_req_gen: RTL and testbench

Request generator sitting directly upstream of the AXI tensor read adapter. It accepts one 2-D tile-load command: base address, row count, beats per row, row stride. It breaks that command into a sequence of AXI read bursts on the tensorcore request interface (`axi_out_*`). It tracks return beats on the `axi_in_*` side so that exactly one burst is outstanding at a time. When the last burst's final beat has arrived, it pulses `done`.

---
 rtl/tensor_rd_req_gen_pkg.sv | 25 ++
 rtl/tensor_rd_req_gen_if.sv | 41 ++++
 rtl/tensor_rd_req_gen_burst_calc.sv | 31 +++
 rtl/tensor_rd_req_gen.sv | 177 +++++++++++++++++
 tb/tb_tensor_rd_req_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tensor_rd_req_gen_pkg.sv
// Shared types and constants for the tensor tile read request generator.
// Optional build macro TENSOR_RD_4K_SPLIT_EN (consumed by tensor_rd_burst_calc)
// keeps every burst inside a single 4 KB page.
package tensor_rd_pkg;

  localparam int unsigned BEAT_BYTES   = 32;
  localparam logic [2:0]  AXI_SIZE_32B = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } tensor_rd_state_e;

  typedef struct packed {
    logic [31:0] base;
    logic [15:0] rows;
    logic [15:0] row_beats;
    logic [31:0] stride;
    logic [2:0]  sel;
  } tensor_rd_cmd_t;

endpackage

// File: rtl/tensor_rd_req_gen_if.sv
// Burst request / beat return bundle between the request generator (master)
// and the AXI tensor read adapter (slave).
interface tensor_rd_req_gen_if #(
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] axi_out_BASE;
  logic [5:0]            axi_out_burst_num;
  logic [2:0]            axi_out_burst_size;
  logic                  axi_out_request_valid;
  logic [2:0]            axi_out_sel;
  logic                  axi_out_issend;
  logic                  axi_in_arready;
  logic                  axi_in_valid;
  logic                  axi_in_finish;

  modport master (
    output axi_out_BASE,
    output axi_out_burst_num,
    output axi_out_burst_size,
    output axi_out_request_valid,
    output axi_out_sel,
    output axi_out_issend,
    input  axi_in_arready,
    input  axi_in_valid,
    input  axi_in_finish
  );

  modport slave (
    input  axi_out_BASE,
    input  axi_out_burst_num,
    input  axi_out_burst_size,
    input  axi_out_request_valid,
    input  axi_out_sel,
    input  axi_out_issend,
    output axi_in_arready,
    output axi_in_valid,
    output axi_in_finish
  );

endinterface

// File: rtl/tensor_rd_req_gen_burst_calc.sv
// Burst length selection: min(beats left in row, MAX_BEATS[, beats to 4 KB]).
// Define TENSOR_RD_4K_SPLIT_EN to include the 4 KB page limit term.
module tensor_rd_burst_calc
  import tensor_rd_pkg::*;
#(
  parameter int MAX_BEATS = 64
) (
  input  logic [15:0] beats_left_i,
  input  logic [6:0]  addr_beat_i,   // cur_addr[11:5]: beat index within the 4 KB page
  output logic [6:0]  len_o
);

`ifdef TENSOR_RD_4K_SPLIT_EN
  logic [15:0] to4k;
`else
  logic unused_addr_beat;
  assign unused_addr_beat = ^addr_beat_i;
`endif
  logic [15:0] lim;

  // Smallest of the limiting terms becomes the burst length
  always_comb begin
    lim = (beats_left_i < 16'(MAX_BEATS)) ? beats_left_i : 16'(MAX_BEATS);
`ifdef TENSOR_RD_4K_SPLIT_EN
    to4k = 16'd128 - 16'(addr_beat_i);
    if (to4k < lim) lim = to4k;
`endif
    len_o = 7'(lim);
  end

endmodule

// File: rtl/tensor_rd_req_gen.sv
// Tile-load request generator: splits a 2-D command (base, rows, beats per row,
// stride) into single-outstanding AXI read bursts and tracks the returning beats.
// Build macro TENSOR_RD_4K_SPLIT_EN enables 4 KB page splitting of bursts.
module tensor_rd_req_gen
  import tensor_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BEATS  = 64   // legal 2..64
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [15:0]           cmd_rows,
  input  logic [15:0]           cmd_row_beats,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic [2:0]            cmd_sel,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  tensor_rd_req_gen_if.master   axi,
  output logic                  busy,
  output logic                  done,
  output logic                  beat_err
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_CALC  = ST_CALC;
  localparam logic [2:0] S_ISSUE = ST_ISSUE;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]            state_q,      state_d;
  tensor_rd_cmd_t        cmd_q,        cmd_d;
  logic [ADDR_WIDTH-1:0] row_addr_q,   row_addr_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q,   cur_addr_d;
  logic [15:0]           rows_left_q,  rows_left_d;
  logic [15:0]           beats_left_q, beats_left_d;
  logic [5:0]            num_q,        num_d;      // current burst length - 1
  logic [7:0]            cnt_q,        cnt_d;      // beats received in current burst
  logic                  err_q,        err_d;

  logic [6:0]            calc_len;
  logic [6:0]            len;
  logic [7:0]            cnt_inc;
  logic [15:0]           beats_rem;
  logic [15:0]           rows_rem;
  logic [ADDR_WIDTH-1:0] row_next;

  // Base and row count are only needed at acceptance; kept for observability
  logic unused_cmd;
  assign unused_cmd = ^{cmd_q.base, cmd_q.rows};

  tensor_rd_burst_calc #(
    .MAX_BEATS (MAX_BEATS)
  ) u_calc (
    .beats_left_i (beats_left_q),
    .addr_beat_i  (cur_addr_q[11:5]),
    .len_o        (calc_len)
  );

  // Working values for the beat-tracking arithmetic
  always_comb begin
    len       = {1'b0, num_q} + 7'd1;
    cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    beats_rem = beats_left_q - 16'(len);
    rows_rem  = rows_left_q - 16'd1;
    row_next  = row_addr_q + ADDR_WIDTH'(cmd_q.stride);
  end

  // Next-state logic: command latch, burst issue and beat accounting
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    row_addr_d   = row_addr_q;
    cur_addr_d   = cur_addr_q;
    rows_left_d  = rows_left_q;
    beats_left_d = beats_left_q;
    num_d        = num_q;
    cnt_d        = cnt_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d.base      = 32'(cmd_base);
          cmd_d.rows      = cmd_rows;
          cmd_d.row_beats = cmd_row_beats;
          cmd_d.stride    = 32'(cmd_stride);
          cmd_d.sel       = cmd_sel;
          row_addr_d      = cmd_base;
          cur_addr_d      = cmd_base;
          rows_left_d     = cmd_rows;
          beats_left_d    = cmd_row_beats;
          err_d           = 1'b0;
          state_d = (cmd_rows == 16'd0 || cmd_row_beats == 16'd0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        num_d   = 6'(calc_len - 7'd1);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (axi.axi_in_arready) begin
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (axi.axi_in_valid) begin
          cnt_d = cnt_inc;
          if (axi.axi_in_finish) begin
            if (cnt_inc != {1'b0, len}) err_d = 1'b1;
            cur_addr_d   = cur_addr_q + ADDR_WIDTH'(len) * ADDR_WIDTH'(BEAT_BYTES);
            beats_left_d = beats_rem;
            state_d      = S_CALC;
            // Row finished: rewind to the start of the next row
            if (beats_rem == 16'd0) begin
              rows_left_d  = rows_rem;
              row_addr_d   = row_next;
              cur_addr_d   = row_next;
              beats_left_d = cmd_q.row_beats;
              if (rows_rem == 16'd0) state_d = S_DONE;
            end
          end else if (cnt_inc == {1'b0, len}) begin
            // Last expected beat came without finish
            err_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Stray beats outside a burst are flagged even on the acceptance cycle
    if (axi.axi_in_valid && state_q != S_WAIT) err_d = 1'b1;
  end

  // State and datapath registers; reset forces all outputs to idle values
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      row_addr_q   <= '0;
      cur_addr_q   <= '0;
      rows_left_q  <= '0;
      beats_left_q <= '0;
      num_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      row_addr_q   <= row_addr_d;
      cur_addr_q   <= cur_addr_d;
      rows_left_q  <= rows_left_d;
      beats_left_q <= beats_left_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ready                 = (state_q == S_IDLE);
  assign busy                      = (state_q != S_IDLE);
  assign done                      = (state_q == S_DONE);
  assign beat_err                  = err_q;
  assign axi.axi_out_request_valid = (state_q == S_ISSUE);
  assign axi.axi_out_BASE          = cur_addr_q;
  assign axi.axi_out_burst_num     = num_q;
  assign axi.axi_out_burst_size    = AXI_SIZE_32B;
  assign axi.axi_out_sel           = cmd_q.sel;
  assign axi.axi_out_issend        = 1'b0;

endmodule

// File: tb/tb_tensor_rd_req_gen.sv
// Scoreboard bench for tensor_rd_req_gen: a reference splitter pushes expected
// bursts per command; each issued request is popped and compared.
module tb_tensor_rd_req_gen;
  import tensor_rd_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] cmd_base;
  logic [15:0] cmd_rows;
  logic [15:0] cmd_row_beats;
  logic [31:0] cmd_stride;
  logic [2:0]  cmd_sel;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        busy;
  logic        done;
  logic        beat_err;

  tensor_rd_req_gen_if #(.ADDR_WIDTH(32)) axi ();

  tensor_rd_req_gen #(.ADDR_WIDTH(32), .MAX_BEATS(64)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cmd_base      (cmd_base),
    .cmd_rows      (cmd_rows),
    .cmd_row_beats (cmd_row_beats),
    .cmd_stride    (cmd_stride),
    .cmd_sel       (cmd_sel),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .axi           (axi.master),
    .busy          (busy),
    .done          (done),
    .beat_err      (beat_err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] base;
    logic [5:0]  num;
    logic [2:0]  sel;
  } burst_t;

  burst_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference splitter: walk each row in page-aware chunks
  task automatic model_cmd(input logic [31:0] base, input int rows, input int rb,
                           input logic [31:0] stride, input logic [2:0] sel);
    logic [31:0] row_a;
    logic [31:0] cur;
    int left;
    int len;
    int to_page;
    burst_t b;
    row_a = base;
    for (int r = 0; r < rows; r++) begin
      cur  = row_a;
      left = rb;
      while (left > 0) begin
        len = (left < 64) ? left : 64;
`ifdef TENSOR_RD_4K_SPLIT_EN
        to_page = (4096 - int'(cur % 4096)) / 32;
        if (to_page < len) len = to_page;
`else
        to_page = 0;
`endif
        b.base = cur;
        b.num  = 6'(len - 1);
        b.sel  = sel;
        exp_q.push_back(b);
        cur  = cur + 32'(len * 32);
        left = left - len;
      end
      row_a = row_a + stride;
    end
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_rv"},    32'(axi.axi_out_request_valid), 32'd0);
    chk({name, "_base"},  axi.axi_out_BASE,               32'd0);
    chk({name, "_num"},   32'(axi.axi_out_burst_num),     32'd0);
    chk({name, "_size"},  32'(axi.axi_out_burst_size),    32'd5);
    chk({name, "_sel"},   32'(axi.axi_out_sel),           32'd0);
    chk({name, "_send"},  32'(axi.axi_out_issend),        32'd0);
    chk({name, "_ready"}, 32'(cmd_ready),                 32'd1);
    chk({name, "_busy"},  32'(busy),                      32'd0);
    chk({name, "_done"},  32'(done),                      32'd0);
    chk({name, "_err"},   32'(beat_err),                  32'd0);
  endtask

  task automatic accept_cmd(input logic [31:0] base, input logic [15:0] rows, input logic [15:0] rb,
                            input logic [31:0] stride, input logic [2:0] sel, input string name);
    chk({name, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_base      = base;
    cmd_rows      = rows;
    cmd_row_beats = rb;
    cmd_stride    = stride;
    cmd_sel       = sel;
    cmd_valid     = 1'b1;
    tick();
    cmd_valid     = 1'b0;
    chk({name, "_busy"},    32'(busy),     32'd1);
    chk({name, "_errclr"},  32'(beat_err), 32'd0);
  endtask

  // Wait for a request (expected one edge after entry) and compare it with the scoreboard
  task automatic take_request(input string name, input int ar_delay, output burst_t e, output bit ok);
    int cyc;
    cyc = 0;
    ok  = 1'b0;
    e   = '0;
    while (!axi.axi_out_request_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!axi.axi_out_request_valid) begin
      chk({name, "_rv_timeout"}, 32'(axi.axi_out_request_valid), 32'd1);
      return;
    end
    chk({name, "_latency"}, 32'(cyc), 32'd1);
    if (exp_q.size() == 0) begin
      chk({name, "_unexpected_req"}, 32'(axi.axi_out_request_valid), 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({name, "_BASE"}, axi.axi_out_BASE,            e.base);
    chk({name, "_num"},  32'(axi.axi_out_burst_num),  32'(e.num));
    chk({name, "_sel"},  32'(axi.axi_out_sel),        32'(e.sel));
    chk({name, "_size"}, 32'(axi.axi_out_burst_size), 32'd5);
    chk({name, "_send"}, 32'(axi.axi_out_issend),     32'd0);
    axi.axi_in_arready = 1'b0;
    for (int d = 0; d < ar_delay; d++) begin
      tick();
      chk({name, "_hold_rv"},   32'(axi.axi_out_request_valid), 32'd1);
      chk({name, "_hold_BASE"}, axi.axi_out_BASE,               e.base);
      chk({name, "_hold_num"},  32'(axi.axi_out_burst_num),     32'(e.num));
    end
    axi.axi_in_arready = 1'b1;
    tick();
    axi.axi_in_arready = 1'b0;
    chk({name, "_rv_drop"}, 32'(axi.axi_out_request_valid), 32'd0);
    ok = 1'b1;
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      axi.axi_in_valid  = 1'b1;
      axi.axi_in_finish = (i == n - 1);
      tick();
    end
    axi.axi_in_valid  = 1'b0;
    axi.axi_in_finish = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] base, input logic [15:0] rows, input logic [15:0] rb,
                         input logic [31:0] stride, input logic [2:0] sel, input int ar_delay,
                         input int early_burst, input bit exp_err, input string name);
    burst_t e;
    bit ok;
    int nb;
    exp_q.delete();
    model_cmd(base, int'(rows), int'(rb), stride, sel);
    nb = exp_q.size();
    accept_cmd(base, rows, rb, stride, sel, name);
    if (nb == 0) begin
      chk({name, "_done"},    32'(done),                      32'd1);
      chk({name, "_noreq"},   32'(axi.axi_out_request_valid), 32'd0);
      tick();
      chk({name, "_done_end"}, 32'(done),      32'd0);
      chk({name, "_idle"},     32'(cmd_ready), 32'd1);
      return;
    end
    for (int b = 0; b < nb; b++) begin
      take_request(name, (b == 0) ? ar_delay : 0, e, ok);
      if (!ok) begin
        exp_q.delete();
        return;
      end
      if (b != nb - 1) chk({name, "_nodone"}, 32'(done), 32'd0);
      send_beats((b == early_burst) ? 2 : int'(e.num) + 1);
    end
    chk({name, "_done"},     32'(done),     32'd1);
    chk({name, "_beat_err"}, 32'(beat_err), 32'(exp_err));
    tick();
    chk({name, "_done_end"}, 32'(done),      32'd0);
    chk({name, "_idle"},     32'(cmd_ready), 32'd1);
    chk({name, "_left"},     32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    burst_t e;
    bit ok;
    areset             = 1'b1;
    cmd_base           = '0;
    cmd_rows           = '0;
    cmd_row_beats      = '0;
    cmd_stride         = '0;
    cmd_sel            = '0;
    cmd_valid          = 1'b0;
    axi.axi_in_arready = 1'b0;
    axi.axi_in_valid   = 1'b0;
    axi.axi_in_finish  = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    areset = 1'b0;
    tick();

    run_cmd(32'h0000_0000, 16'd1, 16'd100, 32'h0,      3'd2, 0, -1, 1'b0, "row100");
    run_cmd(32'h0000_0FC0, 16'd1, 16'd10,  32'h0,      3'd1, 0, -1, 1'b0, "page");
    run_cmd(32'h0000_0100, 16'd3, 16'd4,   32'h400,    3'd5, 5, -1, 1'b0, "stride");
    run_cmd(32'h0000_3000, 16'd2, 16'd4,   32'h80,     3'd3, 0,  0, 1'b1, "early");
    run_cmd(32'h0000_0040, 16'd0, 16'd5,   32'h100,    3'd4, 0, -1, 1'b0, "rows0");
    run_cmd(32'h0000_0040, 16'd2, 16'd0,   32'h100,    3'd4, 0, -1, 1'b0, "beats0");
    run_cmd(32'h0000_0E00, 16'd2, 16'd70,  32'h1000,   3'd7, 2, -1, 1'b0, "multi");
    run_cmd(32'hFFFF_FFC0, 16'd1, 16'd3,   32'h0,      3'd6, 0, -1, 1'b0, "wrap");

    // Stray beat while idle raises the sticky error; next command clears it
    axi.axi_in_valid = 1'b1;
    tick();
    axi.axi_in_valid = 1'b0;
    chk("stray_err", 32'(beat_err), 32'd1);
    run_cmd(32'h0000_2000, 16'd1, 16'd8, 32'h0, 3'd1, 0, -1, 1'b0, "after_stray");

    // Reset in the middle of a burst's beat stream
    exp_q.delete();
    model_cmd(32'h0000_5000, 1, 8, 32'h0, 3'd2);
    accept_cmd(32'h0000_5000, 16'd1, 16'd8, 32'h0, 3'd2, "midrst");
    take_request("midrst", 0, e, ok);
    axi.axi_in_valid  = 1'b1;
    axi.axi_in_finish = 1'b0;
    tick();
    tick();
    axi.axi_in_valid  = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd1);
    areset = 1'b1;
    #2;
    check_reset_vals("midrst_rst");
    exp_q.delete();
    tick();
    areset = 1'b0;
    tick();
    run_cmd(32'h0000_0100, 16'd3, 16'd4, 32'h400, 3'd5, 0, -1, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
